// File: rtl/seg7_pkg.sv
// Shared types and segment constants for the BCD 7-segment counter.
// Segment byte layout: bit7=a .. bit1=g, bit0=dp, active-high.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hE6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Non-decimal nibbles collapse to zero so the counter never holds an illegal digit.
    function automatic bcd_digit_t bcd_clip(input bcd_digit_t d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/seg7_bcd_counter_if.sv
// Control and display bundle between a host and seg7_bcd_counter.
interface seg7_bcd_counter_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    en;
    logic                    up;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [8*NUM_DIGITS-1:0] seg;
    logic                    wrap;

    modport master (output en, up, load, load_val, input bcd, seg, wrap);
    modport slave  (input en, up, load, load_val, output bcd, seg, wrap);
endinterface

// File: rtl/seg7_decode.sv
// Combinational single-digit BCD to 7-segment decode; non-BCD codes go dark.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [7:0]  seg
);

    // Digit lookup.
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_bcd_counter.sv
// Prescaled up/down BCD counter with registered 7-segment outputs.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_bcd_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int CLK_DIV    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg7_bcd_counter_if.slave bus
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = 8 * NUM_DIGITS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    function automatic logic [SW-1:0] seg_reset_val();
        logic [SW-1:0] v;
        v = {SW{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            v[8*k +: 8] = (k == 0) ? SEG_0 : SEG_BLANK;
`else
            v[8*k +: 8] = SEG_0;
`endif
        end
        return v;
    endfunction

    localparam logic [SW-1:0] SEG_RST = seg_reset_val();

    logic [1:0]    rst_sync_r;
    logic [PW-1:0] presc_r;
    logic [BW-1:0] bcd_r;
    logic [SW-1:0] seg_r;
    logic          wrap_r;
    logic          tick_s;
    logic          carry_s;
    logic [BW-1:0] bcd_next_s;
    logic [BW-1:0] load_clean_s;
    logic [SW-1:0] seg_dec_s;
    logic [SW-1:0] seg_next_s;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // Tick, decimal step with ripple carry/borrow, and load sanitising.
    always_comb begin
        tick_s       = bus.en && (presc_r == PRESC_MAX);
        bcd_next_s   = bcd_r;
        load_clean_s = {BW{1'b0}};
        carry_s      = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            load_clean_s[4*k +: 4] = bcd_clip(bus.load_val[4*k +: 4]);
            if (!carry_s) begin
                bcd_next_s[4*k +: 4] = bcd_r[4*k +: 4];
            end else if (bus.up) begin
                if (bcd_r[4*k +: 4] == 4'd9) begin
                    bcd_next_s[4*k +: 4] = 4'd0;
                end else begin
                    bcd_next_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd1;
                    carry_s              = 1'b0;
                end
            end else begin
                if (bcd_r[4*k +: 4] == 4'd0) begin
                    bcd_next_s[4*k +: 4] = 4'd9;
                end else begin
                    bcd_next_s[4*k +: 4] = bcd_r[4*k +: 4] - 4'd1;
                    carry_s              = 1'b0;
                end
            end
        end
    end

    // Counter, prescaler and wrap pulse; load beats a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= {PW{1'b0}};
            bcd_r   <= {BW{1'b0}};
            wrap_r  <= 1'b0;
        end else if (!rst_sync_r[1]) begin
            presc_r <= {PW{1'b0}};
            bcd_r   <= {BW{1'b0}};
            wrap_r  <= 1'b0;
        end else if (bus.load) begin
            presc_r <= {PW{1'b0}};
            bcd_r   <= load_clean_s;
            wrap_r  <= 1'b0;
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
            bcd_r   <= bcd_next_s;
            wrap_r  <= carry_s;
        end else if (bus.en) begin
            presc_r <= presc_r + PW'(1'b1);
            wrap_r  <= 1'b0;
        end else begin
            wrap_r  <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .digit (bcd_r[4*g +: 4]),
            .seg   (seg_dec_s[8*g +: 8])
        );
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lead_s;

    // Scan from the top digit down; a digit is blank while everything above it is zero.
    always_comb begin
        seg_next_s = seg_dec_s;
        lead_s     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead_s = lead_s && (bcd_r[4*k +: 4] == 4'd0);
            if (lead_s) begin
                seg_next_s[8*k +: 8] = SEG_BLANK;
            end else begin
                seg_next_s[8*k +: 8] = seg_dec_s[8*k +: 8];
            end
        end
    end
`else
    assign seg_next_s = seg_dec_s;
`endif

    // Segment register trails bcd by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_RST;
        end else if (!rst_sync_r[1]) begin
            seg_r <= SEG_RST;
        end else begin
            seg_r <= seg_next_s;
        end
    end

    assign bus.bcd  = bcd_r;
    assign bus.seg  = seg_r;
    assign bus.wrap = wrap_r;

endmodule

// File: doc/seg7_bcd_counter.md
SEG7_BCD_COUNTER -- requirements
Module: seg7_bcd_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 3: number of BCD digits and 7-segment outputs; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 1: clock cycles per count step; legal range 1..2^24.
REQ-003 clk  input  1: single clock, all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 en  input  1: count enable; low freezes the counter and the prescaler.
REQ-006 up  input  1: direction; 1 counts up, 0 counts down.
REQ-007 load  input  1: synchronous load strobe.
REQ-008 load_val  input  4*NUM_DIGITS: BCD value to load; digit 0 in bits [3:0].
REQ-009 bcd  output  4*NUM_DIGITS: registered current count in BCD; digit 0 in bits [3:0].
REQ-010 seg  output  8*NUM_DIGITS: registered segment patterns; digit k in bits [8k+7:8k]; per byte bit7=a ... bit1=g, bit0=dp; active-high.
REQ-011 wrap  output  1: one-cycle pulse on a count step that wraps the counter.

Function
REQ-012 Prescaler counts 0..CLK_DIV-1 while en=1; a tick is generated in the cycle it equals CLK_DIV-1, after which it returns to 0.
REQ-013 CLK_DIV=1: tick is generated every cycle with en=1.
REQ-014 On a tick with up=1, bcd increments by one in decimal with per-digit carry; all-9s becomes all-0s and wrap=1.
REQ-015 On a tick with up=0, bcd decrements by one in decimal with per-digit borrow; all-0s becomes all-9s and wrap=1.
REQ-016 load=1 takes priority over a tick in the same cycle; bcd takes load_val next edge, prescaler clears to 0, wrap=0.
REQ-017 Any load_val nibble greater than 9 is loaded as 0 for that digit only.
REQ-018 load is honoured regardless of en.
REQ-019 up is sampled only on tick cycles; changing it between ticks has no effect on the prescaler.
REQ-020 wrap is registered and asserts in the same cycle bcd shows the wrapped value.
REQ-021 seg is the decode of bcd, registered: seg reflects a new bcd value one clock after bcd changes.
REQ-022 Decode per digit: 0=0xFC, 1=0x60, 2=0xDA, 3=0xF2, 4=0x66, 5=0xB6, 6=0xBE, 7=0xE0, 8=0xFE, 9=0xE6; dp bit always 0.
REQ-023 en=0 holds bcd, seg, and prescaler values; wrap=0.

Reset
REQ-024 rst_n low asynchronously sets bcd to all 0, prescaler to 0, and wrap to 0.
REQ-025 rst_n low asynchronously sets every seg byte to 0xFC.
REQ-026 Release is synchronised internally with a two-flop deassertion synchroniser; first tick is no earlier than CLK_DIV cycles after synchronised release.
REQ-027 Reset mid-count or mid-prescale discards all progress; no wrap pulse is produced.

Configuration
REQ-028 Macro SEG7_LEADING_ZERO_BLANK_EN defined: any seg byte for a zero digit more significant than the highest nonzero digit reads 0x00; digit 0 is never blanked; the reset value of seg stays 0x00 for digits 1..N-1 and 0xFC for digit 0.
REQ-029 Macro SEG7_LEADING_ZERO_BLANK_EN undefined: every digit is decoded per REQ-022 and there is no blanking logic.

Structure
REQ-030 Shared package seg7_pkg holds the ten digit segment constants, the blank constant 0x00, and the BCD digit type (4 bits).
REQ-031 Sub-module seg7_decode holds the combinational 4-bit BCD to 8-bit segment decode, instantiated NUM_DIGITS times.
REQ-032 Out-of-range codes input to seg7_decode yield 0x00.

Verification
REQ-033 Run with NUM_DIGITS=3 and CLK_DIV=1: reset, then en=1 and up=1 for 1000 cycles -> bcd reads 0x999 then 0x000; wrap is high for exactly that one cycle; one cycle later seg=0xFCFCFC.
REQ-034 Run with CLK_DIV=4: en=1 and up=1 from reset -> bcd steps 000->001 on the 4th enabled cycle; toggling en low for 2 cycles mid-prescale delays the step by exactly 2 cycles.
REQ-035 Run with up=0 from reset -> next tick gives bcd=0x999, wrap=1, and one cycle later seg=0xE6E6E6.
REQ-036 Drive load=1 with load_val=0x1A7 on the same cycle as a tick -> bcd=0x107 and wrap=0; the following tick gives 0x108.
REQ-037 Assert rst_n low asynchronously between clock edges at bcd=0x456 -> bcd=0x000 and seg=0xFCFCFC immediately, with no clock edge required.
REQ-038 Build with SEG7_LEADING_ZERO_BLANK_EN at bcd=0x007 -> seg=0x0000E0; at bcd=0x070 -> seg=0x00E0FC.
